systolic_skew_feeder: RTL
=========================

# systolic_skew_feeder

Upstream operand feeder for the 8x8 systolic multiply array. It holds one 8x8 A matrix and one 8x8 B matrix, loaded row by row. On `start` it streams them into the array's `left_in`/`top_in` buses with the diagonal skew the array needs: row i of A is delayed i cycles and column j of B is delayed j cycles. It then idles the buses while the array drains, and pulses `done` when every PE holds its final dot product.

## Interface
- DATA_WIDTH, 8, signed operand width; must match the array's DATA_WIDTH.
- N, 8, array dimension; fixed at 8 for this block; other values are unsupported.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  load one matrix row this cycle.
- wr_sel  input  1  0 = write A, 1 = write B.
- wr_row  input  3  row index 0..7.
- wr_data  input  DATA_WIDTH*8  row contents; element k occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- start  input  1  begin a stream pass.
- busy  output  1  pass in progress (FEED or DRAIN).
- done  output  1  one-cycle pulse; array results are final.
- feed_valid  output  1  high during FEED cycles.
- left_out  output  DATA_WIDTH*8  to array `left_in`; element i drives row i.
- top_out  output  DATA_WIDTH*8  to array `top_in`; element j drives column j.

## Operation
- Storage: A[8][8] and B[8][8], signed DATA_WIDTH.
  - wr_en with wr_sel=0 writes A[wr_row][k] = wr_data element k.
  - wr_sel=1 writes B[wr_row][k] likewise; row r of B is K-index r.
- States:
  - IDLE: start=1 → FEED, step counter t=0.
  - FEED: t = 0..14; at t=14 → DRAIN, drain counter d=0.
  - DRAIN: d = 0..6; at d=6 → DONE.
  - DONE: one cycle → IDLE.
- FEED output at step t, all outputs registered:
  - left_out[i] = A[i][t-i] when 0 ≤ t-i ≤ 7, else 0.
  - top_out[j] = B[t-j][j] when 0 ≤ t-j ≤ 7, else 0.
- IDLE, DRAIN and DONE drive left_out = top_out = 0, so the array's accumulators are not disturbed.
- busy = 1 in FEED and DRAIN. done = 1 only in DONE. feed_valid = 1 only in FEED.
- wr_en while busy=1 is ignored; storage is unchanged.
- wr_en and start in the same IDLE cycle: the write commits first, and the pass uses the newly written row.
- start while busy=1 is ignored.
- start in the DONE cycle is accepted: the next cycle is FEED t=0.
- Clearing the array's accumulators between passes is the array's own reset and is outside this block. The feeder never resets the array.
- Pure data movement; no arithmetic on operands, no width change.

## Timing
- Reset (reset=0, asynchronous assertion) clears:
  - state to IDLE, counters to 0;
  - left_out = top_out = 0;
  - busy = done = feed_valid = 0;
  - all A and B entries to 0.
- Reset asserted mid-pass aborts immediately; no done pulse follows.
- Deassertion is synchronous to clk; the first edge after release may accept start.
- start sampled high at edge of cycle c:
  - cycles c+1..c+15 are FEED t=0..14;
  - cycles c+16..c+22 are DRAIN;
  - cycle c+23 has done=1, busy=0.
  - Total 22 busy cycles.
- Basis for 7 DRAIN cycles: A[7][7] leaves the feeder at t=14. It reaches PE(7,7) after 7 further array hops, so the last product accumulates at c+22.
- Back-to-back passes: start held high continuously gives a new pass every 23 cycles.

## Test plan
- Identity: A = I, B[r][k] = 8r+k. Start, wait for done → array result[i][j] = B[i][j]. Check done exactly 23 cycles after the start edge.
- Skew check: A[i][k] = 16i+k, B = 0. Check left_out[i] at FEED step t equals 16i+(t-i) inside the window and 0 outside, for all t = 0..14. Check feed_valid is high for exactly 15 cycles.
- Signed extremes: all A = -128, all B = -128 → each array result = 8·16384 (checks the array's ACC_WIDTH). Feeder outputs are bit-exact 0x80 in-window.
- Write blocked while busy: start a pass, write A[3] = all 0x7F during FEED → stored A[3] unchanged. A second pass reproduces the first pass's output stream exactly.
- Reset mid-pass: pull reset low at FEED t=5 → outputs 0 and busy 0 in the same cycle, done never pulses, A and B read back as 0 on the next pass.
- Start in DONE cycle and start while busy: start at c+10 is ignored. Start at c+23 gives FEED t=0 at c+24 with no idle cycle.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
// Load/stream bus between a controller and the systolic operand feeder.
// The master drives row writes and start; the slave returns status and the skewed operand buses.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8
);
    logic                       wr_en;
    logic                       wr_sel;
    logic [2:0]                 wr_row;
    logic [DATA_WIDTH*N-1:0]    wr_data;
    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       feed_valid;
    logic [DATA_WIDTH*N-1:0]    left_out;
    logic [DATA_WIDTH*N-1:0]    top_out;

    modport master (
        output wr_en, wr_sel, wr_row, wr_data, start,
        input  busy, done, feed_valid, left_out, top_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_data, start,
        output busy, done, feed_valid, left_out, top_out
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an 8x8 systolic array: stores A and B, then streams them with
// row/column diagonal skew (FEED), idles while the array drains, and pulses done.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    systolic_skew_feeder_if.slave  fbus
);
    localparam int         BUS_W  = DATA_WIDTH * N;
    localparam logic [3:0] T_LAST = 4'd14;
    localparam logic [2:0] D_LAST = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] t_q, t_d;
    logic [2:0] d_q, d_d;

    logic signed [DATA_WIDTH-1:0] a_q [N][N];
    logic signed [DATA_WIDTH-1:0] a_d [N][N];
    logic signed [DATA_WIDTH-1:0] b_q [N][N];
    logic signed [DATA_WIDTH-1:0] b_d [N][N];

    logic [BUS_W-1:0] left_q, left_d;
    logic [BUS_W-1:0] top_q, top_d;
    logic             busy_q, done_q, fv_q;
    logic             wr_ok;
    logic [3:0]       idx;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        d_d     = d_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                t_d = '0;
                d_d = '0;
                state_d = fbus.start ? S_FEED : S_IDLE;
            end
            S_FEED: begin
                if (t_q == T_LAST) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                    d_d     = '0;
                end else begin
                    t_d = t_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (d_q == D_LAST) begin
                    state_d = S_DONE;
                    d_d     = '0;
                end else begin
                    d_d = d_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is writable only outside a pass; a write coinciding with start lands before the first feed step.
    assign wr_ok = fbus.wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (wr_ok) begin
            for (int k = 0; k < N; k++) begin
                if (!fbus.wr_sel) a_d[fbus.wr_row][k] = fbus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                else              b_d[fbus.wr_row][k] = fbus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Outputs are computed from next-state values so the registered bus shows step t during FEED step t.
    always_comb begin
        left_d = '0;
        top_d  = '0;
        idx    = '0;
        if (state_d == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                if (t_d >= 4'(i)) begin
                    idx = t_d - 4'(i);
                    if (idx <= 4'd7) begin
                        left_d[i*DATA_WIDTH +: DATA_WIDTH] = a_d[i][idx[2:0]];
                        top_d[i*DATA_WIDTH +: DATA_WIDTH]  = b_d[idx[2:0]][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            d_q     <= '0;
            left_q  <= '0;
            top_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fv_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_q[i][k] <= '0;
                    b_q[i][k] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            d_q     <= d_d;
            left_q  <= left_d;
            top_q   <= top_d;
            busy_q  <= (state_d == S_FEED) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
            fv_q    <= (state_d == S_FEED);
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign fbus.busy       = busy_q;
    assign fbus.done       = done_q;
    assign fbus.feed_valid = fv_q;
    assign fbus.left_out   = left_q;
    assign fbus.top_out    = top_q;
endmodule
